// File: rtl/trig_pkg.sv
// trig_pkg: shared types and helpers for the trigger stream encoder.
//   trig_state_t : encoder FSM states
//   FRAME_LEN    : bits per frame (start, tag[1], tag[0], parity)
//   TAG_W        : tag width
//   PEND_W       : pending-counter width (holds DEPTH up to 15)
//   GAP_W        : gap-counter width (holds MIN_GAP up to 7)
//   odd_parity() : parity bit that makes tag ^ parity odd; also used by the decoder model
package trig_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StStrt,
      StTb1,
      StTb0,
      StPrty,
      StGap
   } trig_state_t;

   localparam int unsigned FRAME_LEN = 4;
   localparam int unsigned TAG_W     = 2;
   localparam int unsigned PEND_W    = 4;
   localparam int unsigned GAP_W     = 3;

   function automatic logic odd_parity(input logic [TAG_W-1:0] tag);
      return ~(^tag);
   endfunction

endpackage

// File: rtl/sat_counter16.sv
// sat_counter16: 16-bit event counter that sticks at 0xFFFF instead of wrapping.
// Ports:
//   clk   in   clock
//   rst_n in   asynchronous active-low clear
//   inc   in   count one event this cycle
//   count out  current count (registered)
module sat_counter16 (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        inc,
   output logic [15:0] count
);

   logic [15:0] count_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else if (inc && (count_q != 16'hFFFF)) begin
         count_q <= count_q + 16'd1;
      end
   end

   assign count = count_q;

endmodule

// File: rtl/trigger_encoder.sv
// trigger_encoder: serialises accepted triggers into 4-bit frames on a 1-wire stream
// (start=1, tag[1], tag[0], odd parity), followed by MIN_GAP forced-idle cycles.
// Triggers arriving during a frame queue in a pending counter of depth DEPTH;
// excess triggers are dropped and counted.
// Parameters:
//   DEPTH   (1..15) maximum pending triggers
//   MIN_GAP (0..7)  idle cycles on Trig after each parity bit
// Ports:
//   Clock        in   system clock
//   ResetN       in   asynchronous active-low reset
//   TrigIn       in   trigger request pulse, sampled each rising edge
//   Enable       in   gates acceptance of new TrigIn pulses
//   ForcePrtyErr in   invert parity of the next dispatched frame (TRIG_PARITY_INJECT_EN only)
//   Trig         out  serial trigger stream (registered)
//   Tag          out  tag of the most recently started frame
//   Busy         out  frame in flight, gap running, or triggers pending
//   NTrig        out  frames sent, saturating
//   NDropped     out  triggers dropped on overflow, saturating
// Build option: define TRIG_PARITY_INJECT_EN to enable parity-error injection.
module trigger_encoder
   import trig_pkg::*;
#(
   parameter int unsigned DEPTH   = 4,
   parameter int unsigned MIN_GAP = 1
) (
   input  logic        Clock,
   input  logic        ResetN,
   input  logic        TrigIn,
   input  logic        Enable,
   input  logic        ForcePrtyErr,
   output logic        Trig,
   output logic [1:0]  Tag,
   output logic        Busy,
   output logic [15:0] NTrig,
   output logic [15:0] NDropped
);

   localparam logic [PEND_W-1:0] DepthMax = PEND_W'(DEPTH);
   localparam logic [GAP_W-1:0]  GapLast  = GAP_W'((MIN_GAP == 0) ? 0 : MIN_GAP - 1);

   trig_state_t       state_q;
   logic [PEND_W-1:0] pending_q, pending_d;
   logic [TAG_W-1:0]  tag_cnt_q;
   logic [TAG_W-1:0]  tag_q;
   logic [GAP_W-1:0]  gap_q;
   logic              req_q;
   logic              trig_q;
   logic              busy_q;
   logic              inj_q;

   logic accept;
   logic ready;
   logic dispatch;
   logic overflow;
   logic force_sample;

`ifdef TRIG_PARITY_INJECT_EN
   assign force_sample = ForcePrtyErr;
`else
   logic unused_force;
   assign unused_force = ForcePrtyErr;
   assign force_sample = 1'b0;
`endif

   // TrigIn/Enable are captured at the edge they are sampled; the request is acted on
   // one edge later, which is the edge that drives the start bit.
   always_ff @(posedge Clock or negedge ResetN) begin
      if (!ResetN) begin
         req_q <= 1'b0;
      end else begin
         req_q <= Enable && TrigIn;
      end
   end

   assign accept = req_q;

   // The last cycle of a frame (end of gap, or parity when there is no gap) behaves as
   // IDLE for dispatch, so back-to-back frames repeat every 4+MIN_GAP cycles.
   always_comb begin
      ready = 1'b0;
      unique case (state_q)
         StIdle:  ready = 1'b1;
         StPrty:  ready = (MIN_GAP == 0);
         StGap:   ready = (gap_q == '0);
         default: ready = 1'b0;
      endcase
   end

   assign dispatch = ready && ((pending_q != '0) || accept);
   assign overflow = accept && !dispatch && (pending_q == DepthMax);

   // Bypass (accept + dispatch together) leaves the counter alone.
   always_comb begin
      pending_d = pending_q;
      if (accept && !dispatch && !overflow) begin
         pending_d = pending_q + 1'b1;
      end else if (dispatch && !accept) begin
         pending_d = pending_q - 1'b1;
      end
   end

   always_ff @(posedge Clock or negedge ResetN) begin
      if (!ResetN) begin
         pending_q <= '0;
      end else begin
         pending_q <= pending_d;
      end
   end

   always_ff @(posedge Clock or negedge ResetN) begin
      if (!ResetN) begin
         state_q   <= StIdle;
         trig_q    <= 1'b0;
         tag_q     <= '0;
         tag_cnt_q <= '0;
         gap_q     <= '0;
         inj_q     <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         if (dispatch) begin
            state_q   <= StStrt;
            trig_q    <= 1'b1;
            tag_q     <= tag_cnt_q;
            tag_cnt_q <= tag_cnt_q + 1'b1;
            inj_q     <= force_sample;
         end else begin
            unique case (state_q)
               StIdle: begin
                  trig_q <= 1'b0;
               end
               StStrt: begin
                  state_q <= StTb1;
                  trig_q  <= tag_q[1];
               end
               StTb1: begin
                  state_q <= StTb0;
                  trig_q  <= tag_q[0];
               end
               StTb0: begin
                  state_q <= StPrty;
                  trig_q  <= odd_parity(tag_q) ^ inj_q;
               end
               StPrty: begin
                  trig_q <= 1'b0;
                  if (MIN_GAP > 0) begin
                     state_q <= StGap;
                     gap_q   <= GapLast;
                  end else begin
                     state_q <= StIdle;
                  end
               end
               StGap: begin
                  trig_q <= 1'b0;
                  if (gap_q == '0) begin
                     state_q <= StIdle;
                  end else begin
                     gap_q <= gap_q - 1'b1;
                  end
               end
               default: begin
                  state_q <= StIdle;
                  trig_q  <= 1'b0;
               end
            endcase
         end
         // Without a dispatch, a ready state falls to IDLE; every other state stays busy.
         busy_q <= !(ready && !dispatch) || (pending_d != '0);
      end
   end

   sat_counter16 u_ntrig (
      .clk   (Clock),
      .rst_n (ResetN),
      .inc   (dispatch),
      .count (NTrig)
   );

   sat_counter16 u_ndropped (
      .clk   (Clock),
      .rst_n (ResetN),
      .inc   (overflow),
      .count (NDropped)
   );

   assign Trig = trig_q;
   assign Tag  = tag_q;
   assign Busy = busy_q;

endmodule
